// File: rtl/mmio_io_pkg.sv
// Shared constants for the MMIO display controller: register word offsets,
// STATUS bit positions and the 7-segment glyph table ({a,b,c,d,e,f,g,dp}).
package mmio_io_pkg;

   localparam logic [2:0] OFF_SW     = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_LED    = 3'd2;
   localparam logic [2:0] OFF_SEG    = 3'd3;
   localparam logic [2:0] OFF_BLANK  = 3'd4;
   localparam logic [2:0] OFF_DP     = 3'd5;

   localparam int STAT_FLAG_BIT  = 0;
   localparam int STAT_LEVEL_BIT = 1;

   localparam logic [7:0] SEG_GLYPH [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to 7-segment glyph lookup; dp bit is always 0.
module seg_hex_decoder
   import mmio_io_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] glyph
);

   always_comb begin
      glyph = SEG_GLYPH[nibble];
   end

endmodule

// File: rtl/mmio_display_ctrl.sv
// MMIO peripheral: latched switches, debounced confirm button with sticky flag,
// LED port and multiplexed 7-seg display. Optional DP register: MMIO_SEG_DP_EN.
module mmio_display_ctrl
   import mmio_io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC00,
   parameter int          NUM_DIGITS = 8,
   parameter int          SW_WIDTH   = 16,
   parameter int          LED_WIDTH  = 16,
   parameter int          SCAN_DIV   = 100000,
   parameter int          DEB_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           addr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data,
   input  logic [SW_WIDTH-1:0]   sw_in,
   input  logic                  btn_confirm,
   output logic [LED_WIDTH-1:0]  led_out,
   output logic [NUM_DIGITS-1:0] seg_sel,
   output logic [7:0]            seg_left,
   output logic [7:0]            seg_right
);

   localparam int HALF   = NUM_DIGITS / 2;
   localparam int SEG_W  = NUM_DIGITS * 4;
   localparam int DIG_W  = $clog2(NUM_DIGITS);
   localparam int PH_W   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int PRE_W  = $clog2(SCAN_DIV);
   localparam int DEB_W  = $clog2(DEB_CYCLES);
   localparam logic [NUM_DIGITS-1:0] SEL_RST =
      NUM_DIGITS'(1) | (NUM_DIGITS'(1) << HALF);

   logic                  hit, wr_hit, rd_hit, btn_rise;
   logic [2:0]            offset;
   logic [31:0]           rd_word;
   logic [DIG_W-1:0]      sel_r, sel_l;
   logic [3:0]            nib_r, nib_l;
   logic [7:0]            glyph_r, glyph_l;
   logic                  dp_r, dp_l;
   logic [3:0]            digit_nib [NUM_DIGITS];

   logic [SW_WIDTH-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_reg_q, sw_reg_d;
   logic                  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic                  btn_level_q, btn_level_d, flag_q, flag_d;
   logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
   logic [LED_WIDTH-1:0]  led_q, led_d;
   logic [SEG_W-1:0]      seg_data_q, seg_data_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
`ifdef MMIO_SEG_DP_EN
   logic [NUM_DIGITS-1:0] dp_q, dp_d;
`endif
   logic [31:0]           rd_data_q, rd_data_d;
   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
   logic [7:0]            seg_left_q, seg_left_d, seg_right_q, seg_right_d;

   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wr_data};

   always_comb begin
      hit    = (addr[31:5] == BASE_ADDR[31:5]);
      offset = addr[4:2];
      wr_hit = wr_en && hit;
      rd_hit = rd_en && hit;

      sw_s1_d  = sw_in;
      sw_s2_d  = sw_s1_q;
      btn_s1_d = btn_confirm;
      btn_s2_d = btn_s1_q;

      led_d      = led_q;
      seg_data_d = seg_data_q;
      blank_d    = blank_q;
`ifdef MMIO_SEG_DP_EN
      dp_d       = dp_q;
`endif
      if (wr_hit) begin
         case (offset)
            OFF_LED:   led_d      = wr_data[LED_WIDTH-1:0];
            OFF_SEG:   seg_data_d = wr_data[SEG_W-1:0];
            OFF_BLANK: blank_d    = wr_data[NUM_DIGITS-1:0];
`ifdef MMIO_SEG_DP_EN
            OFF_DP:    dp_d       = wr_data[NUM_DIGITS-1:0];
`endif
            default: ;
         endcase
      end

      // The counter only runs while the synchronised button disagrees with the
      // accepted level, so any bounce back to the old level restarts it.
      deb_cnt_d   = '0;
      btn_level_d = btn_level_q;
      if (btn_s2_q != btn_level_q) begin
         if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) btn_level_d = btn_s2_q;
         else deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      btn_rise = btn_level_d && !btn_level_q;
      sw_reg_d = btn_rise ? sw_s2_q : sw_reg_q;

      flag_d = flag_q;
      if (rd_hit && offset == OFF_STATUS) flag_d = 1'b0;
      if (btn_rise) flag_d = 1'b1;

      rd_word = '0;
      case (offset)
         OFF_SW:     rd_word = 32'(sw_reg_q);
         OFF_STATUS: begin
            rd_word[STAT_LEVEL_BIT] = btn_level_q;
            rd_word[STAT_FLAG_BIT]  = flag_q;
         end
         OFF_LED:    rd_word = 32'(led_q);
         OFF_SEG:    rd_word = 32'(seg_data_q);
         OFF_BLANK:  rd_word = 32'(blank_q);
`ifdef MMIO_SEG_DP_EN
         OFF_DP:     rd_word = 32'(dp_q);
`endif
         default: ;
      endcase
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = hit ? rd_word : 32'h0;

      pre_d   = pre_q + PRE_W'(1);
      phase_d = phase_q;
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_d   = '0;
         phase_d = (phase_q == PH_W'(HALF - 1)) ? '0 : phase_q + PH_W'(1);
      end

      // Segment outputs are built from next-state values so register writes
      // reach the display in the same edge that commits them.
      for (int i = 0; i < NUM_DIGITS; i++) digit_nib[i] = seg_data_d[4*i +: 4];
      sel_r = DIG_W'(phase_d);
      sel_l = sel_r + DIG_W'(HALF);
      nib_r = digit_nib[sel_r];
      nib_l = digit_nib[sel_l];
`ifdef MMIO_SEG_DP_EN
      dp_r = dp_d[sel_r];
      dp_l = dp_d[sel_l];
`else
      dp_r = 1'b0;
      dp_l = 1'b0;
`endif
   end

   seg_hex_decoder u_dec_right (.nibble(nib_r), .glyph(glyph_r));
   seg_hex_decoder u_dec_left  (.nibble(nib_l), .glyph(glyph_l));

   always_comb begin
      seg_sel_d        = '0;
      seg_sel_d[sel_r] = 1'b1;
      seg_sel_d[sel_l] = 1'b1;
      seg_right_d = blank_d[sel_r] ? 8'h00 : (glyph_r | {7'b0, dp_r});
      seg_left_d  = blank_d[sel_l] ? 8'h00 : (glyph_l | {7'b0, dp_l});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         sw_reg_q    <= '0;
         btn_s1_q    <= 1'b0;
         btn_s2_q    <= 1'b0;
         btn_level_q <= 1'b0;
         flag_q      <= 1'b0;
         deb_cnt_q   <= '0;
         led_q       <= '0;
         seg_data_q  <= '0;
         blank_q     <= '0;
`ifdef MMIO_SEG_DP_EN
         dp_q        <= '0;
`endif
         rd_data_q   <= '0;
         pre_q       <= '0;
         phase_q     <= '0;
         seg_sel_q   <= SEL_RST;
         seg_left_q  <= SEG_GLYPH[0];
         seg_right_q <= SEG_GLYPH[0];
      end else begin
         sw_s1_q     <= sw_s1_d;
         sw_s2_q     <= sw_s2_d;
         sw_reg_q    <= sw_reg_d;
         btn_s1_q    <= btn_s1_d;
         btn_s2_q    <= btn_s2_d;
         btn_level_q <= btn_level_d;
         flag_q      <= flag_d;
         deb_cnt_q   <= deb_cnt_d;
         led_q       <= led_d;
         seg_data_q  <= seg_data_d;
         blank_q     <= blank_d;
`ifdef MMIO_SEG_DP_EN
         dp_q        <= dp_d;
`endif
         rd_data_q   <= rd_data_d;
         pre_q       <= pre_d;
         phase_q     <= phase_d;
         seg_sel_q   <= seg_sel_d;
         seg_left_q  <= seg_left_d;
         seg_right_q <= seg_right_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign led_out   = led_q;
   assign seg_sel   = seg_sel_q;
   assign seg_left  = seg_left_q;
   assign seg_right = seg_right_q;

endmodule

// File: tb/tb_mmio_display_ctrl.sv
// Self-checking bench for mmio_display_ctrl: per-cycle reference model plus
// directed literal checks. Honours MMIO_SEG_DP_EN when defined.
module tb_mmio_display_ctrl;

   localparam int SCAN = 4;
   localparam int DEB  = 8;
`ifdef MMIO_SEG_DP_EN
   localparam bit DP_EN = 1'b1;
`else
   localparam bit DP_EN = 1'b0;
`endif
   localparam logic [31:0] BASE = 32'hFFFF_FC00;
   localparam logic [7:0] GLYPH [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0, wr_data = '0;
   logic        wr_en = 1'b0, rd_en = 1'b0, btn_confirm = 1'b0;
   logic [15:0] sw_in = '0;
   logic [31:0] rd_data;
   logic [15:0] led_out;
   logic [7:0]  seg_sel, seg_left, seg_right;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mmio_display_ctrl #(
      .BASE_ADDR(BASE), .NUM_DIGITS(8), .SW_WIDTH(16), .LED_WIDTH(16),
      .SCAN_DIV(SCAN), .DEB_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
      .wr_data(wr_data), .rd_data(rd_data), .sw_in(sw_in),
      .btn_confirm(btn_confirm), .led_out(led_out), .seg_sel(seg_sel),
      .seg_left(seg_left), .seg_right(seg_right)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_rd, m_seg;
   logic [15:0] m_led, m_sw;
   logic [7:0]  m_blank, m_dp;
   logic        m_flag, m_level;
   int          m_cycles;
   logic        btn_hist [$];
   logic [15:0] sw_hist [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_seg(input int d);
      logic [3:0] nib;
      nib = m_seg[4*d +: 4];
      if (m_blank[d]) return 8'h00;
      return GLYPH[nib] | {7'b0, DP_EN & m_dp[d]};
   endfunction

   always @(posedge clk or posedge rst) begin : model
      logic [31:0] nrd;
      logic        nflag, nlevel, same, hit;
      logic [15:0] nsw;
      logic [2:0]  off;
      if (rst) begin
         m_rd <= '0; m_seg <= '0; m_led <= '0; m_sw <= '0;
         m_blank <= '0; m_dp <= '0; m_flag <= 1'b0; m_level <= 1'b0;
         m_cycles <= 0;
         btn_hist.delete();
         sw_hist.delete();
      end else begin
         nrd = m_rd; nflag = m_flag; nlevel = m_level; nsw = m_sw;
         hit = (addr[31:5] == BASE[31:5]);
         off = addr[4:2];
         if (rd_en) begin
            nrd = '0;
            if (hit) begin
               case (off)
                  3'd0: nrd = {16'h0, m_sw};
                  3'd1: nrd = {30'h0, m_level, m_flag};
                  3'd2: nrd = {16'h0, m_led};
                  3'd3: nrd = m_seg;
                  3'd4: nrd = {24'h0, m_blank};
                  3'd5: nrd = DP_EN ? {24'h0, m_dp} : 32'h0;
                  default: nrd = '0;
               endcase
               if (off == 3'd1) nflag = 1'b0;
            end
         end
         if (wr_en && hit) begin
            case (off)
               3'd2: m_led <= wr_data[15:0];
               3'd3: m_seg <= wr_data;
               3'd4: m_blank <= wr_data[7:0];
               3'd5: if (DP_EN) m_dp <= wr_data[7:0];
               default: ;
            endcase
         end
         // Synchronised button seen before edge e is the raw value at edge e-2.
         btn_hist.push_front(btn_confirm);
         sw_hist.push_front(sw_in);
         if (btn_hist.size() > DEB + 2) begin
            void'(btn_hist.pop_back());
            void'(sw_hist.pop_back());
         end
         if (btn_hist.size() == DEB + 2) begin
            same = 1'b1;
            for (int i = 2; i < DEB + 2; i++) if (btn_hist[i] != btn_hist[2]) same = 1'b0;
            if (same && btn_hist[2] != m_level) begin
               nlevel = btn_hist[2];
               if (nlevel) begin
                  nflag = 1'b1;
                  nsw = sw_hist[2];
               end
            end
         end
         m_rd <= nrd; m_flag <= nflag; m_level <= nlevel; m_sw <= nsw;
         m_cycles <= m_cycles + 1;
      end
   end

   always @(posedge clk) begin : compare
      int p;
      #1;
      if (chk_en && !rst) begin
         p = (m_cycles / SCAN) % 4;
         check("rd_data", rd_data, m_rd);
         check("led_out", {16'h0, led_out}, {16'h0, m_led});
         check("seg_sel", {24'h0, seg_sel}, {24'h0, 8'(8'h11 << p)});
         check("seg_right", {24'h0, seg_right}, {24'h0, exp_seg(p)});
         check("seg_left", {24'h0, seg_left}, {24'h0, exp_seg(p + 4)});
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wr_data = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      addr = a; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic wait_sel(input logic [7:0] v, input string name);
      int n = 0;
      while (seg_sel !== v && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, {24'h0, seg_sel}, {24'h0, v});
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // 1: async reset in the middle of a scan
      bus_write(BASE + 32'h08, 32'h0000_1234);
      bus_read(BASE + 32'h08);
      check("pre_reset_rd", rd_data, 32'h0000_1234);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_seg_sel", {24'h0, seg_sel}, 32'h11);
      check("rst_seg_left", {24'h0, seg_left}, 32'hFC);
      check("rst_seg_right", {24'h0, seg_right}, 32'hFC);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_led", {16'h0, led_out}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 2: LED write, upper bits dropped
      bus_write(BASE + 32'h08, 32'h0001_A5A5);
      check("led_write", {16'h0, led_out}, 32'h0000_A5A5);
      bus_read(BASE + 32'h08);
      check("led_read", rd_data, 32'h0000_A5A5);

      // 3: scan sequence
      bus_write(BASE + 32'h0C, 32'h1234_5678);
      wait_sel(8'h11, "scan_p0");
      check("p0_left", {24'h0, seg_left}, 32'h66);
      check("p0_right", {24'h0, seg_right}, 32'hFE);
      wait_sel(8'h22, "scan_p1");
      check("p1_left", {24'h0, seg_left}, 32'hF2);
      check("p1_right", {24'h0, seg_right}, 32'hE0);
      wait_sel(8'h44, "scan_p2");
      wait_sel(8'h88, "scan_p3");
      wait_sel(8'h11, "scan_wrap");

      // 4: bounce then hold, one confirm
      sw_in = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         btn_confirm = (i % 2 == 0);
         @(negedge clk);
      end
      btn_confirm = 1'b1;
      repeat (12) @(negedge clk);
      sw_in = 16'h1111;
      bus_read(BASE + 32'h00);
      check("sw_capture", rd_data, 32'h0000_BEEF);
      bus_read(BASE + 32'h04);
      check("status_first", rd_data, 32'h3);
      bus_read(BASE + 32'h04);
      check("status_second", rd_data, 32'h2);
      btn_confirm = 1'b0;
      repeat (14) @(negedge clk);
      bus_read(BASE + 32'h04);
      check("status_release", rd_data, 32'h0);

      // 5: blank and dp
      bus_write(BASE + 32'h10, 32'hFFFF_FF01);
      bus_write(BASE + 32'h14, 32'h0000_0002);
      bus_read(BASE + 32'h10);
      check("blank_read", rd_data, 32'h0000_0001);
      bus_read(BASE + 32'h14);
      check("dp_read", rd_data, DP_EN ? 32'h2 : 32'h0);
      wait_sel(8'h11, "blank_p0");
      check("blank_right", {24'h0, seg_right}, 32'h00);
      check("blank_left", {24'h0, seg_left}, 32'h66);
      wait_sel(8'h22, "dp_p1");
      check("dp_right", {24'h0, seg_right}, DP_EN ? 32'hE1 : 32'hE0);

      // Same-cycle read and write returns the old value
      addr = BASE + 32'h08; wr_data = 32'h0000_5A5A; rd_en = 1'b1; wr_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      check("rdwr_old", rd_data, 32'h0000_A5A5);
      check("rdwr_new_led", {16'h0, led_out}, 32'h0000_5A5A);

      // 6: misses
      bus_read(32'hFFFF_FFF0);
      check("miss_read", rd_data, 32'h0);
      bus_write(32'h0000_1000, 32'hFFFF_FFFF);
      bus_write(32'h0000_1008, 32'hFFFF_FFFF);
      check("miss_led", {16'h0, led_out}, 32'h0000_5A5A);
      bus_read(BASE + 32'h0C);
      check("miss_seg", rd_data, 32'h1234_5678);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
